// File: rtl/axi4lite_ram_port_a_if.sv
// rtl/axi4lite_ram_port_a_if.sv - AXI4-Lite bus bundle between an AXI master and the RAM port-A front-end
interface axi4lite_ram_port_a_if #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32
);
  logic [AXI_ADDR_W-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [AXI_DATA_W-1:0]   wdata;
  logic [AXI_DATA_W/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [AXI_ADDR_W-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [AXI_DATA_W-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4lite_ram_port_a.sv
// rtl/axi4lite_ram_port_a.sv - AXI4-Lite slave that serialises reads and writes onto a RAM port A
module axi4lite_ram_port_a #(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 8,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axi4lite_ram_port_a_if.slave s_axi,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [DATA_W-1:0]    ram_din,
  input  logic [DATA_W-1:0]    ram_dout
);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_RESP,
    RD_ISSUE,
    RD_DATA,
    RD_RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  last_wr_q, last_wr_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  in_range_q, in_range_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  wstrb0_q, wstrb0_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [AXI_DATA_W-1:0] rdata_q, rdata_d;
  logic                  ram_en_q, ram_en_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]     ram_din_q, ram_din_d;

  logic wr_req, rd_req, grant_wr, grant_rd;
  logic aw_in_range, ar_in_range;

  // Address bits and byte lanes the narrow port-A datapath never looks at.
  logic unused_bits;
  assign unused_bits = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0],
                         s_axi.wdata[AXI_DATA_W-1:DATA_W], s_axi.wstrb[AXI_DATA_W/8-1:1]};

  assign aw_in_range = ~|s_axi.awaddr[AXI_ADDR_W-1:ADDR_W+2];
  assign ar_in_range = ~|s_axi.araddr[AXI_ADDR_W-1:ADDR_W+2];

  // Round-robin grant in IDLE: on a conflict the type not served last wins; readys stay low in reset.
  always_comb begin
    wr_req   = s_axi.awvalid & s_axi.wvalid;
    rd_req   = s_axi.arvalid;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (aresetn && state_q == IDLE) begin
      if (wr_req && (!rd_req || !last_wr_q)) begin
        grant_wr = 1'b1;
      end else if (rd_req) begin
        grant_rd = 1'b1;
      end
    end
  end

  // Next-state and next-output logic; every output is registered one cycle behind the state.
  always_comb begin
    state_d    = state_q;
    last_wr_d  = last_wr_q;
    addr_d     = addr_q;
    in_range_d = in_range_q;
    wdata_d    = wdata_q;
    wstrb0_d   = wstrb0_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    ram_en_d   = 1'b0;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;

    unique case (state_q)
      IDLE: begin
        if (grant_wr) begin
          addr_d     = s_axi.awaddr[ADDR_W+1:2];
          in_range_d = aw_in_range;
          wdata_d    = s_axi.wdata[DATA_W-1:0];
          wstrb0_d   = s_axi.wstrb[0];
          last_wr_d  = 1'b1;
          state_d    = WR_ISSUE;
        end else if (grant_rd) begin
          addr_d     = s_axi.araddr[ADDR_W+1:2];
          in_range_d = ar_in_range;
          last_wr_d  = 1'b0;
          state_d    = RD_ISSUE;
        end
      end
      WR_ISSUE: begin
        // A cleared byte-0 strobe is a legal no-op: no RAM cycle, but still OKAY.
        ram_en_d   = in_range_q & wstrb0_q;
        ram_we_d   = in_range_q & wstrb0_q;
        ram_addr_d = addr_q;
        ram_din_d  = wdata_q;
        state_d    = WR_RESP;
      end
      WR_RESP: begin
        if (!bvalid_q) begin
          bvalid_d = 1'b1;
          bresp_d  = in_range_q ? RESP_OKAY : RESP_SLVERR;
        end else if (s_axi.bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      RD_ISSUE: begin
        ram_en_d   = in_range_q;
        ram_addr_d = addr_q;
        state_d    = RD_DATA;
      end
      RD_DATA: begin
        // RAM samples the enabled read at the end of this cycle.
        state_d = RD_RESP;
      end
      RD_RESP: begin
        if (!rvalid_q) begin
          rvalid_d = 1'b1;
          rdata_d  = '0;
          if (in_range_q) begin
            rdata_d[DATA_W-1:0] = ram_dout;
          end
          rresp_d  = in_range_q ? RESP_OKAY : RESP_SLVERR;
        end else if (s_axi.rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      last_wr_q  <= 1'b0;
      addr_q     <= '0;
      in_range_q <= 1'b0;
      wdata_q    <= '0;
      wstrb0_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
      rresp_q    <= 2'b00;
      rdata_q    <= '0;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_wr_q  <= last_wr_d;
      addr_q     <= addr_d;
      in_range_q <= in_range_d;
      wdata_q    <= wdata_d;
      wstrb0_q   <= wstrb0_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      ram_en_q   <= ram_en_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
    end
  end

  assign s_axi.awready = grant_wr;
  assign s_axi.wready  = grant_wr;
  assign s_axi.arready = grant_rd;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;
  assign ram_en        = ram_en_q;
  assign ram_we        = ram_we_q;
  assign ram_addr      = ram_addr_q;
  assign ram_din       = ram_din_q;
endmodule

// File: tb/tb_axi4lite_ram_port_a.sv
// tb/tb_axi4lite_ram_port_a.sv - scoreboard bench for the AXI4-Lite RAM port-A front-end
module tb_axi4lite_ram_port_a;
  localparam int ADDR_W     = 3;
  localparam int DATA_W     = 8;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic [DATA_W-1:0] mem [0:7];

  axi4lite_ram_port_a_if #(.AXI_ADDR_W(AXI_ADDR_W), .AXI_DATA_W(AXI_DATA_W)) s_axi ();

  axi4lite_ram_port_a #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AXI_ADDR_W(AXI_ADDR_W), .AXI_DATA_W(AXI_DATA_W)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .s_axi(s_axi),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 aclk = ~aclk;

  // Port-A RAM model: registered read-first output.
  always @(posedge aclk) begin
    if (ram_en === 1'b1) begin
      if (ram_we === 1'b1) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  int n_vec  = 0;
  int n_miss = 0;

  bit          grant_q [$];
  logic [1:0]  b_q     [$];
  logic [33:0] r_q     [$];
  logic [11:0] ram_q   [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: event occurred that was not expected or did not occur in time", name);
  endtask

  // ---------------- monitor ----------------
  int          cyc = 0;
  int          aw_edge = 0, ar_edge = 0;
  logic        prev_bvalid = 1'b0, prev_rvalid = 1'b0;
  logic        b_hs_last = 1'b0, r_hs_last = 1'b0;
  logic [1:0]  bresp_hold = 2'b00;
  logic [33:0] r_hold = '0;
  logic [11:0] ram_exp;

  always @(posedge aclk) cyc <= cyc + 1;

  always @(negedge aclk) begin
    if (s_axi.awready === 1'b1 || s_axi.wready === 1'b1) begin
      check("wr_grant_joint", 64'({s_axi.awready, s_axi.wready, s_axi.awvalid, s_axi.wvalid}), 64'hF);
      check("wr_grant_excl", 64'(s_axi.arready), 64'h0);
      if (grant_q.size() == 0) fail("wr_grant_unexpected");
      else check("grant_order_wr", 64'(grant_q.pop_front()), 64'h0);
      aw_edge = cyc + 1;
    end
    if (s_axi.arready === 1'b1) begin
      check("rd_grant_valid", 64'(s_axi.arvalid), 64'h1);
      if (grant_q.size() == 0) fail("rd_grant_unexpected");
      else check("grant_order_rd", 64'(grant_q.pop_front()), 64'h1);
      ar_edge = cyc + 1;
    end
    if (s_axi.bvalid === 1'b1 || s_axi.rvalid === 1'b1)
      check("no_ready_while_busy", 64'({s_axi.awready, s_axi.wready, s_axi.arready}), 64'h0);

    if (b_hs_last) check("bvalid_drop", 64'(s_axi.bvalid), 64'h0);
    b_hs_last = 1'b0;
    if (s_axi.bvalid === 1'b1) begin
      if (prev_bvalid !== 1'b1) begin
        check("b_latency", 64'(cyc - aw_edge), 64'd2);
        if (b_q.size() == 0) fail("b_unexpected");
        else check("bresp", 64'(s_axi.bresp), 64'(b_q.pop_front()));
      end else begin
        check("b_stable", 64'(s_axi.bresp), 64'(bresp_hold));
      end
      bresp_hold = s_axi.bresp;
      if (s_axi.bready === 1'b1) b_hs_last = 1'b1;
    end
    prev_bvalid = (s_axi.bvalid === 1'b1);

    if (r_hs_last) check("rvalid_drop", 64'(s_axi.rvalid), 64'h0);
    r_hs_last = 1'b0;
    if (s_axi.rvalid === 1'b1) begin
      if (prev_rvalid !== 1'b1) begin
        check("r_latency", 64'(cyc - ar_edge), 64'd3);
        if (r_q.size() == 0) fail("r_unexpected");
        else check("rresp_rdata", 64'({s_axi.rresp, s_axi.rdata}), 64'(r_q.pop_front()));
      end else begin
        check("r_stable", 64'({s_axi.rresp, s_axi.rdata}), 64'(r_hold));
      end
      r_hold = {s_axi.rresp, s_axi.rdata};
      if (s_axi.rready === 1'b1) r_hs_last = 1'b1;
    end
    prev_rvalid = (s_axi.rvalid === 1'b1);

    if (ram_en === 1'b1) begin
      if (ram_q.size() == 0) fail("ram_unexpected");
      else begin
        ram_exp = ram_q.pop_front();
        check("ram_we", 64'(ram_we), 64'(ram_exp[11]));
        check("ram_addr", 64'(ram_addr), 64'(ram_exp[10:8]));
        if (ram_exp[11]) check("ram_din", 64'(ram_din), 64'(ram_exp[7:0]));
      end
    end
  end

  // ---------------- expectations ----------------
  task automatic exp_wr(input logic [7:0] d, input bit ram_hit, input logic [2:0] word, input logic [1:0] resp);
    grant_q.push_back(1'b0);
    if (ram_hit) ram_q.push_back({1'b1, word, d});
    b_q.push_back(resp);
  endtask

  task automatic exp_rd(input logic [7:0] d, input bit ram_hit, input logic [2:0] word, input logic [1:0] resp);
    grant_q.push_back(1'b1);
    if (ram_hit) ram_q.push_back({1'b0, word, 8'h00});
    r_q.push_back({resp, 24'h0, d});
  endtask

  // ---------------- drivers ----------------
  task automatic start_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    s_axi.awaddr  = a;
    s_axi.wdata   = d;
    s_axi.wstrb   = st;
    s_axi.awvalid = 1'b1;
    s_axi.wvalid  = 1'b1;
  endtask

  task automatic finish_wr();
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge aclk);
      if (s_axi.awready === 1'b1 && s_axi.wready === 1'b1) ok = 1'b1;
    end
    @(posedge aclk); #1;
    s_axi.awvalid = 1'b0;
    s_axi.wvalid  = 1'b0;
    if (!ok) fail("wr_handshake_timeout");
  endtask

  task automatic start_rd(input logic [31:0] a);
    s_axi.araddr  = a;
    s_axi.arvalid = 1'b1;
  endtask

  task automatic finish_rd();
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge aclk);
      if (s_axi.arready === 1'b1) ok = 1'b1;
    end
    @(posedge aclk); #1;
    s_axi.arvalid = 1'b0;
    if (!ok) fail("rd_handshake_timeout");
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    @(posedge aclk); #1;
    start_wr(a, d, st);
    finish_wr();
  endtask

  task automatic do_rd(input logic [31:0] a);
    @(posedge aclk); #1;
    start_rd(a);
    finish_rd();
  endtask

  task automatic wait_quiet();
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge aclk);
      if (grant_q.size() == 0 && b_q.size() == 0 && r_q.size() == 0 && ram_q.size() == 0 &&
          s_axi.bvalid === 1'b0 && s_axi.rvalid === 1'b0) ok = 1'b1;
    end
    if (!ok) fail("quiet_timeout");
  endtask

  task automatic wait_valid(input bit is_r);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge aclk);
      if ((is_r ? s_axi.rvalid : s_axi.bvalid) === 1'b1) ok = 1'b1;
    end
    if (!ok) fail(is_r ? "rvalid_timeout" : "bvalid_timeout");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    ram_dout      = 8'h00;
    aresetn       = 1'b0;
    s_axi.awaddr  = '0;
    s_axi.awvalid = 1'b0;
    s_axi.wdata   = '0;
    s_axi.wstrb   = '0;
    s_axi.wvalid  = 1'b0;
    s_axi.araddr  = '0;
    s_axi.arvalid = 1'b0;
    s_axi.bready  = 1'b1;
    s_axi.rready  = 1'b1;

    // Reset with every valid high; then the held pair arbitrates write-first.
    exp_wr(8'h55, 1'b1, 3'd2, 2'b00);
    exp_rd(8'h00, 1'b1, 3'd6, 2'b00);
    exp_wr(8'h33, 1'b1, 3'd4, 2'b00);
    start_wr(32'h08, 32'h55, 4'h1);
    start_rd(32'h18);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_awready", 64'(s_axi.awready), 64'h0);
    check("rst_wready", 64'(s_axi.wready), 64'h0);
    check("rst_arready", 64'(s_axi.arready), 64'h0);
    check("rst_bvalid", 64'(s_axi.bvalid), 64'h0);
    check("rst_rvalid", 64'(s_axi.rvalid), 64'h0);
    check("rst_ram_en", 64'(ram_en), 64'h0);
    check("rst_rdata", 64'(s_axi.rdata), 64'h0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    fork
      begin
        finish_wr();
        start_wr(32'h10, 32'h33, 4'h1);
        finish_wr();
      end
      finish_rd();
    join
    wait_quiet();

    // Fresh simultaneous pair after a write grant: read goes first.
    exp_rd(8'h33, 1'b1, 3'd4, 2'b00);
    exp_wr(8'h77, 1'b1, 3'd5, 2'b00);
    @(posedge aclk); #1;
    start_wr(32'h14, 32'h77, 4'h1);
    start_rd(32'h10);
    fork
      finish_wr();
      finish_rd();
    join
    wait_quiet();

    // Write then read back, including ignored low address bits.
    exp_wr(8'hA5, 1'b1, 3'd3, 2'b00);
    do_wr(32'h0C, 32'h0000_00A5, 4'h1);
    wait_quiet();
    exp_rd(8'hA5, 1'b1, 3'd3, 2'b00);
    do_rd(32'h0C);
    wait_quiet();
    exp_rd(8'hA5, 1'b1, 3'd3, 2'b00);
    do_rd(32'h0D);
    wait_quiet();
    exp_rd(8'h55, 1'b1, 3'd2, 2'b00);
    do_rd(32'h08);
    wait_quiet();
    exp_rd(8'h77, 1'b1, 3'd5, 2'b00);
    do_rd(32'h14);
    wait_quiet();

    // Byte-0 strobe clear: no RAM write, OKAY, word stays 0.
    exp_wr(8'hEE, 1'b0, 3'd7, 2'b00);
    do_wr(32'h1C, 32'hEE, 4'hE);
    wait_quiet();
    exp_rd(8'h00, 1'b1, 3'd7, 2'b00);
    do_rd(32'h1C);
    wait_quiet();

    // Out of range accesses.
    exp_wr(8'h5A, 1'b0, 3'd0, 2'b10);
    do_wr(32'h40, 32'h5A, 4'h1);
    wait_quiet();
    exp_rd(8'h00, 1'b0, 3'd0, 2'b10);
    do_rd(32'h40);
    wait_quiet();
    exp_rd(8'h00, 1'b0, 3'd1, 2'b10);
    do_rd(32'h8000_0004);
    wait_quiet();

    // Backpressure on B with a read held pending, then on R.
    exp_wr(8'h11, 1'b1, 3'd1, 2'b00);
    exp_rd(8'h11, 1'b1, 3'd1, 2'b00);
    s_axi.bready = 1'b0;
    do_wr(32'h04, 32'h11, 4'h1);
    start_rd(32'h04);
    wait_valid(1'b0);
    repeat (5) @(posedge aclk);
    #1;
    s_axi.bready = 1'b1;
    s_axi.rready = 1'b0;
    finish_rd();
    wait_valid(1'b1);
    repeat (5) @(posedge aclk);
    #1;
    s_axi.rready = 1'b1;
    wait_quiet();

    // Reset while the read sits in RD_ISSUE.
    grant_q.push_back(1'b1);
    do_rd(32'h0C);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    check("midrst_ram_en", 64'(ram_en), 64'h0);
    check("midrst_rvalid", 64'(s_axi.rvalid), 64'h0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    repeat (6) @(posedge aclk);
    check("midrst_no_r", 64'(r_q.size()), 64'h0);
    exp_rd(8'hA5, 1'b1, 3'd3, 2'b00);
    do_rd(32'h0C);
    wait_quiet();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
